uart_fifo_unit: RTL and testbench

//  Memory-mapped UART peripheral with runtime baud divisor, optional parity, 1/2 stop bits and
//  TX/RX FIFOs of parametrised depth. Sits on the CPU data bus beside the timer/LED peripherals;

---
 rtl/uart_fifo_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_unit.sv
// uart_fifo_unit: memory-mapped UART with runtime baud divisor, optional parity,
// one or two stop bits and TX/RX FIFOs. One level interrupt for RX data / TX empty.
module uart_fifo_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h40000018,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        out,
    input  logic        in,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Register decode
    logic sel_txd, sel_rxd, sel_con, sel_div, con_wr, div_wr;
    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == BASE_ADDR + 32'd4);
    assign sel_con = (addr == BASE_ADDR + 32'd8);
    assign sel_div = (addr == BASE_ADDR + 32'd12);
    assign con_wr  = wr & sel_con;
    assign div_wr  = wr & sel_div;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:17];

    logic [4:0]  con_q;
    logic [15:0] div_q;
    logic [15:0] tick_cnt;
    logic        tick;
    logic        ovr_q, frm_q, par_q, txo_q;

    // TX FIFO storage and pointers
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]        tx_wp, tx_rp;
    logic                 tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set;
    logic [DATA_BITS-1:0] tx_head;

    // RX FIFO storage and pointers
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]        rx_wp, rx_rp;
    logic                 rx_empty, rx_full, rx_push, rx_pop, rx_push_req, ovr_set;
    logic [DATA_BITS-1:0] rx_head;

    assign tx_empty   = (tx_wp == tx_rp);
    assign tx_full    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_head    = tx_mem[tx_rp[AW-1:0]];
    assign tx_push    = wr & sel_txd & (~tx_full | tx_pop);
    assign tx_ovf_set = wr & sel_txd & tx_full & ~tx_pop;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];
    assign rx_pop   = rd & sel_rxd & ~rx_empty;
    assign rx_push  = rx_push_req & (~rx_full | rx_pop);
    assign ovr_set  = rx_push_req & rx_full & ~rx_pop;

    // Oversample tick generator; a DIV write restarts the count
    assign tick = (tick_cnt == div_q);
    always_ff @(posedge CLK) begin
        if (Reset || div_wr) tick_cnt <= '0;
        else if (tick)       tick_cnt <= '0;
        else                 tick_cnt <= tick_cnt + 16'd1;
    end

    // Control, divisor and sticky status flags (a new event wins over a clear)
    logic frm_set, par_set;
    always_ff @(posedge CLK) begin
        if (Reset) begin
            con_q <= '0;
            div_q <= DIV_RESET;
            ovr_q <= 1'b0;
            frm_q <= 1'b0;
            par_q <= 1'b0;
            txo_q <= 1'b0;
        end else begin
            if (con_wr) con_q <= wdata[4:0];
            if (div_wr) div_q <= wdata[15:0];
            ovr_q <= ovr_set    | (ovr_q & ~(con_wr & wdata[13]));
            frm_q <= frm_set    | (frm_q & ~(con_wr & wdata[14]));
            par_q <= par_set    | (par_q & ~(con_wr & wdata[15]));
            txo_q <= tx_ovf_set | (txo_q & ~(con_wr & wdata[16]));
        end
    end

    // FIFO pointers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    // FIFO storage writes (no reset needed on data)
    logic [DATA_BITS-1:0] rx_shift;
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
    end

    // ---------------- Transmitter ----------------
    tx_state_t            tx_state, tx_state_nx;
    logic [3:0]           tx_tcnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_par_en, tx_stop2, tx_busy, tx_bit_done;

    assign tx_busy     = (tx_state != TX_IDLE);
    assign tx_bit_done = tick && (tx_tcnt == 4'd15);

    // TX state register
    always_ff @(posedge CLK) begin
        if (Reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_nx;
    end

    // TX next state; a pop starts every frame, including back-to-back ones
    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_state_nx = TX_START;
                    tx_pop      = 1'b1;
                end
            end
            TX_START:  if (tx_bit_done) tx_state_nx = TX_DATA;
            TX_DATA:   if (tx_bit_done && tx_idx == LAST_BIT)
                           tx_state_nx = tx_par_en ? TX_PARITY : TX_STOP1;
            TX_PARITY: if (tx_bit_done) tx_state_nx = TX_STOP1;
            TX_STOP1, TX_STOP2: begin
                if (tx_bit_done) begin
                    if (tx_state == TX_STOP1 && tx_stop2) begin
                        tx_state_nx = TX_STOP2;
                    end else if (!tx_empty) begin
                        tx_state_nx = TX_START;
                        tx_pop      = 1'b1;
                    end else begin
                        tx_state_nx = TX_IDLE;
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    // TX datapath: frame config latched at frame start, line driven from state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            tx_tcnt   <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
            tx_stop2  <= 1'b0;
            out       <= 1'b1;
        end else begin
            if (tx_pop) begin
                tx_shift  <= tx_head;
                tx_par    <= (^tx_head) ^ con_q[3];
                tx_par_en <= con_q[2];
                tx_stop2  <= con_q[4];
                tx_tcnt   <= '0;
                tx_idx    <= '0;
            end else if (tx_busy && tick) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_bit_done && tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_idx   <= tx_idx + BW'(1);
                end
            end
            case (tx_state)
                TX_START:  out <= 1'b0;
                TX_DATA:   out <= tx_shift[0];
                TX_PARITY: out <= tx_par;
                default:   out <= 1'b1;
            endcase
        end
    end

    // ---------------- Receiver ----------------
    rx_state_t     rx_state, rx_state_nx;
    logic          in_s1, rx_s;
    logic [3:0]    rx_tcnt;
    logic [BW-1:0] rx_idx;
    logic          rx_par_en, rx_par_odd, rx_par_bad, rx_bit_done, rx_start_go;

    assign rx_bit_done = tick && (rx_tcnt == 4'd15);

    // RX state register
    always_ff @(posedge CLK) begin
        if (Reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_nx;
    end

    // RX next state; start bit re-checked half a bit later to reject glitches
    always_comb begin
        rx_state_nx = rx_state;
        rx_start_go = 1'b0;
        rx_push_req = 1'b0;
        frm_set     = 1'b0;
        par_set     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (tick && !rx_s) begin
                    rx_state_nx = RX_START;
                    rx_start_go = 1'b1;
                end
            end
            RX_START:  if (tick && rx_tcnt == 4'd7)
                           rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_bit_done && rx_idx == LAST_BIT)
                           rx_state_nx = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_bit_done) rx_state_nx = RX_STOP;
            RX_STOP: begin
                if (rx_bit_done) begin
                    rx_state_nx = RX_IDLE;
                    if (!rx_s)           frm_set     = 1'b1;
                    else if (rx_par_bad) par_set     = 1'b1;
                    else                 rx_push_req = 1'b1;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // RX datapath: synchroniser, mid-bit sampling and parity check
    always_ff @(posedge CLK) begin
        if (Reset) begin
            in_s1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_tcnt    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bad <= 1'b0;
        end else begin
            in_s1 <= in;
            rx_s  <= in_s1;
            if (rx_start_go) begin
                rx_tcnt    <= '0;
                rx_idx     <= '0;
                rx_par_en  <= con_q[2];
                rx_par_odd <= con_q[3];
                rx_par_bad <= 1'b0;
            end else if (tick) begin
                case (rx_state)
                    RX_START: rx_tcnt <= (rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
                    RX_DATA: begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_bit_done) begin
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            rx_idx   <= rx_idx + BW'(1);
                        end
                    end
                    RX_PARITY: begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_bit_done)
                            rx_par_bad <= (rx_s != ((^rx_shift) ^ rx_par_odd));
                    end
                    RX_STOP: rx_tcnt <= rx_tcnt + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // Registered interrupt
    always_ff @(posedge CLK) begin
        if (Reset) irq <= 1'b0;
        else       irq <= (con_q[0] & ~rx_empty) | (con_q[1] & tx_empty & ~tx_busy);
    end

    // Combinational read mux
    logic [31:0] status;
    assign status = {15'd0, txo_q, par_q, frm_q, ovr_q, tx_busy, tx_full, tx_empty,
                     rx_full, rx_empty, 3'd0, con_q};

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd && !rx_empty) rdata = 32'(rx_head);
            else if (sel_con)         rdata = status;
            else if (sel_div)         rdata = {16'd0, div_q};
        end
    end

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Directed testbench for uart_fifo_unit (DATA_BITS=8, FIFO_DEPTH=16).
module tb_uart_fifo_unit;

    localparam logic [31:0] BASE  = 32'h40000018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'd4;
    localparam logic [31:0] A_CON = BASE + 32'd8;
    localparam logic [31:0] A_DIV = BASE + 32'd12;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        out_w, in_w, irq;
    logic        loop_en = 1'b0, tb_in = 1'b1;

    int checks = 0;
    int failures = 0;

    assign in_w = loop_en ? out_w : tb_in;

    always #5 CLK = ~CLK;

    uart_fifo_unit dut (
        .CLK  (CLK),
        .Reset(Reset),
        .rd   (rd),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .out  (out_w),
        .in   (in_w),
        .irq  (irq)
    );

    // Line monitor: decodes 8N1 frames at DIV=0 (16 cycles per bit)
    logic [7:0] mon_q[$];
    logic [7:0] mon_b;
    bit         mon_en = 1'b0;
    always begin
        @(negedge CLK);
        if (mon_en && out_w === 1'b0) begin
            repeat (8) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(negedge CLK);
                mon_b[i] = out_w;
            end
            repeat (16) @(negedge CLK);
            mon_q.push_back(mon_b);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge CLK);
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge CLK);
        rd = 1'b0; addr = '0;
    endtask

    task automatic wait_fall(output bit ok);
        int n = 0;
        while (out_w !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        ok = (out_w === 1'b0);
    endtask

    // Drive one frame on tb_in at 16 cycles per bit, followed by one idle bit
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit po,
                              input bit bad_par, input bit stop_v);
        tb_in = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            tb_in = d[i];
            repeat (16) @(negedge CLK);
        end
        if (pe) begin
            tb_in = (^d) ^ po ^ bad_par;
            repeat (16) @(negedge CLK);
        end
        tb_in = stop_v;
        repeat (16) @(negedge CLK);
        tb_in = 1'b1;
        repeat (16) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_w !== 1'b1) begin failures++; $display("FAIL reset_out got=%b exp=1", out_w); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h500) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h500); end
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'hF) begin failures++; $display("FAIL reset_div got=%h exp=%h", d, 32'hF); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_rxd_empty got=%h exp=0", d); end
        bus_read(A_TXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL txd_read got=%h exp=0", d); end
        bus_read(BASE + 32'd16, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    endtask

    task automatic test_loopback_a5();
        logic [31:0] d;
        logic [7:0]  got;
        bit          ok;
        int          low = 0;
        bus_write(A_DIV, 32'h0);
        bus_write(A_CON, 32'h0);
        loop_en = 1'b1;
        bus_write(A_TXD, 32'hA5);
        wait_fall(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL a5_start got=%b exp=0", out_w); end
        while (out_w === 1'b0 && low < 40) begin
            @(negedge CLK);
            low++;
        end
        checks++;
        if (low != 16) begin failures++; $display("FAIL a5_start_len got=%0d exp=16", low); end
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            got[i] = out_w;
            repeat (16) @(negedge CLK);
        end
        checks++;
        if (got !== 8'hA5) begin failures++; $display("FAIL a5_line_bits got=%h exp=a5", got); end
        repeat (30) @(negedge CLK);
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'hA5) begin failures++; $display("FAIL a5_rxd got=%h exp=%h", d, 32'hA5); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h500) begin failures++; $display("FAIL a5_status got=%h exp=%h", d, 32'h500); end
    endtask

    task automatic test_parity_stop2_b2b();
        logic [31:0] d;
        logic        samp [0:192];
        logic [11:0] frame;
        bit          ok;
        bus_write(A_CON, 32'h1C);
        loop_en = 1'b1;
        bus_write(A_TXD, 32'h03);
        bus_write(A_TXD, 32'h03);
        wait_fall(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL par_start got=%b exp=0", out_w); end
        for (int c = 0; c <= 192; c++) begin
            samp[c] = out_w;
            @(negedge CLK);
        end
        for (int k = 0; k < 12; k++) frame[k] = samp[8 + 16 * k];
        checks++;
        if (frame !== 12'hE06) begin failures++; $display("FAIL par_frame_bits got=%h exp=e06", frame); end
        checks++;
        if (samp[8 + 16 * 9] !== 1'b1) begin failures++; $display("FAIL par_bit got=%b exp=1", samp[152]); end
        checks++;
        if (samp[191] !== 1'b1) begin failures++; $display("FAIL par_stop2_end got=%b exp=1", samp[191]); end
        checks++;
        if (samp[192] !== 1'b0) begin failures++; $display("FAIL par_b2b_start got=%b exp=0", samp[192]); end
        repeat (220) @(negedge CLK);
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h03) begin failures++; $display("FAIL par_rxd0 got=%h exp=3", d); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h03) begin failures++; $display("FAIL par_rxd1 got=%h exp=3", d); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h51C) begin failures++; $display("FAIL par_status got=%h exp=%h", d, 32'h51C); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic [7:0]  exp_b, got_b;
        int          w = 0;
        loop_en = 1'b0;
        tb_in   = 1'b1;
        bus_write(A_CON, 32'h1E002);
        mon_q.delete();
        mon_en = 1'b1;
        bus_write(A_TXD, 32'h5A);
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 17; i++) bus_write(A_TXD, 32'h10 + 32'(i));
        bus_read(A_CON, d);
        checks++;
        if ((d & 32'h11C00) !== 32'h11800) begin
            failures++; $display("FAIL txovf_status got=%h exp=%h", d & 32'h11C00, 32'h11800);
        end
        while (mon_q.size() < 17 && w < 17 * 160 + 400) begin
            @(negedge CLK);
            w++;
        end
        repeat (20) @(negedge CLK);
        mon_en = 1'b0;
        checks++;
        if (mon_q.size() != 17) begin failures++; $display("FAIL txovf_count got=%0d exp=17", mon_q.size()); end
        for (int i = 0; i < 17; i++) begin
            exp_b = (i == 0) ? 8'h5A : 8'(8'h10 + i - 1);
            got_b = (i < mon_q.size()) ? mon_q[i] : 8'h00;
            checks++;
            if (got_b !== exp_b) begin failures++; $display("FAIL txovf_byte%0d got=%h exp=%h", i, got_b, exp_b); end
        end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL txie_irq got=%b exp=1", irq); end
        bus_write(A_CON, 32'h10000);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h500) begin failures++; $display("FAIL txovf_clear got=%h exp=%h", d, 32'h500); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        loop_en = 1'b0;
        tb_in   = 1'b1;
        bus_write(A_CON, 32'h1);
        for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rxie_irq got=%b exp=1", irq); end
        bus_read(A_CON, d);
        checks++;
        if ((d & 32'h2300) !== 32'h2200) begin
            failures++; $display("FAIL rxovr_status got=%h exp=%h", d & 32'h2300, 32'h2200);
        end
        for (int i = 0; i < 16; i++) begin
            bus_read(A_RXD, d);
            checks++;
            if (d !== 32'h30 + 32'(i)) begin failures++; $display("FAIL rxovr_byte%0d got=%h exp=%h", i, d, 32'h30 + 32'(i)); end
        end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h exp=0", d); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h2501) begin failures++; $display("FAIL rxovr_after got=%h exp=%h", d, 32'h2501); end
        repeat (2) @(negedge CLK);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_drop got=%b exp=0", irq); end
        bus_write(A_CON, 32'h1E000);
    endtask

    task automatic test_errors();
        logic [31:0] d;
        loop_en = 1'b0;
        tb_in   = 1'b1;
        bus_write(A_CON, 32'h1E000);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h4500) begin failures++; $display("FAIL frame_err got=%h exp=%h", d, 32'h4500); end
        bus_write(A_CON, 32'h1E00C);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge CLK);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h850C) begin failures++; $display("FAIL parity_err got=%h exp=%h", d, 32'h850C); end
        bus_write(A_CON, 32'h1E000);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          ok;
        bus_write(A_DIV, 32'h0);
        bus_write(A_CON, 32'h0);
        loop_en = 1'b1;
        bus_write(A_TXD, 32'h00);
        wait_fall(ok);
        repeat (30) @(negedge CLK);
        checks++;
        if (!ok || out_w !== 1'b0) begin failures++; $display("FAIL mid_data_low got=%b exp=0", out_w); end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if (out_w !== 1'b1) begin failures++; $display("FAIL mid_reset_out got=%b exp=1", out_w); end
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h500) begin failures++; $display("FAIL mid_reset_status got=%h exp=%h", d, 32'h500); end
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'hF) begin failures++; $display("FAIL mid_reset_div got=%h exp=f", d); end
        loop_en = 1'b0;
        tb_in   = 1'b1;
        repeat (20) @(negedge CLK);
        tb_in = 1'b0;
        repeat (128) @(negedge CLK);
        tb_in = 1'b1;
        repeat (300) @(negedge CLK);
        bus_read(A_CON, d);
        checks++;
        if (d !== 32'h500) begin failures++; $display("FAIL glitch_status got=%h exp=%h", d, 32'h500); end
        bus_read(A_RXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_rxd got=%h exp=0", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_parity_stop2_b2b();
        test_tx_overflow();
        test_rx_overrun();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
